// File: rtl/eth_tx_arbiter.sv
// Frame-granular arbiter sharing one GMII transmit path between ARP, audio and video sources.
// Enforces an inter-frame gap, revokes grants that never start, and cuts frames that run too long.
module eth_tx_arbiter #(
  parameter int IFG_CYCLES       = 12,
  parameter int START_TIMEOUT    = 255,
  parameter int MAX_FRAME_CYCLES = 1530
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arp_req,
  input  logic       arp_tx_en,
  input  logic [7:0] arp_txd,
  input  logic       aud_req,
  input  logic       aud_tx_en,
  input  logic [7:0] aud_txd,
  input  logic       vid_req,
  input  logic       vid_tx_en,
  input  logic [7:0] vid_txd,
  output logic       arp_gnt,
  output logic       aud_gnt,
  output logic       vid_gnt,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       frame_abort,
  output logic       grant_timeout
);
  localparam int IFG_W  = $clog2(IFG_CYCLES + 1);
  localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
  localparam int LEN_W  = $clog2(MAX_FRAME_CYCLES + 1);

  localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_CYCLES - 1);
  localparam logic [IFG_W-1:0]  IFG_MAX   = IFG_W'(IFG_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(START_TIMEOUT);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_FRAME_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SEND, ST_IFG} state_t;
  typedef enum logic [1:0] {SRC_ARP, SRC_AUD, SRC_VID} src_t;

  state_t            state_q, state_d;
  src_t              sel_q, sel_d;
  src_t              rr_ptr_q, rr_ptr_d;
  logic [2:0]        hold_q, hold_d;
  logic              gmii_tx_en_q, gmii_tx_en_d;
  logic [7:0]        gmii_txd_q, gmii_txd_d;
  logic              frame_abort_q, frame_abort_d;
  logic              grant_timeout_q, grant_timeout_d;
  logic [IFG_W-1:0]  ifg_cnt_q, ifg_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;

  logic [2:0] req_vec, en_vec, req_elig;
  logic       src_req, src_tx_en;
  logic [7:0] src_txd;
  logic       busy;

  function automatic src_t rr_after(input src_t sel, input src_t rr);
    if (sel == SRC_AUD) return SRC_VID;
    if (sel == SRC_VID) return SRC_AUD;
    return rr;
  endfunction

  assign req_vec  = {vid_req, aud_req, arp_req};
  assign en_vec   = {vid_tx_en, aud_tx_en, arp_tx_en};
  // A source cut at the length limit stays masked until it lets go of tx_en.
  assign req_elig = req_vec & ~hold_q;

  always_comb begin
    src_req   = 1'b0;
    src_tx_en = 1'b0;
    src_txd   = '0;
    case (sel_q)
      SRC_ARP: begin src_req = arp_req; src_tx_en = arp_tx_en; src_txd = arp_txd; end
      SRC_AUD: begin src_req = aud_req; src_tx_en = aud_tx_en; src_txd = aud_txd; end
      SRC_VID: begin src_req = vid_req; src_tx_en = vid_tx_en; src_txd = vid_txd; end
      default: ;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    rr_ptr_d        = rr_ptr_q;
    hold_d          = hold_q & en_vec;
    gmii_tx_en_d    = 1'b0;
    gmii_txd_d      = '0;
    frame_abort_d   = 1'b0;
    grant_timeout_d = 1'b0;
    ifg_cnt_d       = ifg_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    len_cnt_d       = len_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_elig) begin
          state_d    = ST_GRANT;
          wait_cnt_d = '0;
          if (req_elig[0])              sel_d = SRC_ARP;
          else if (rr_ptr_q == SRC_AUD) sel_d = req_elig[1] ? SRC_AUD : SRC_VID;
          else                          sel_d = req_elig[2] ? SRC_VID : SRC_AUD;
        end
      end
      ST_GRANT: begin
        if (src_tx_en) begin
          state_d      = ST_SEND;
          gmii_tx_en_d = 1'b1;
          gmii_txd_d   = src_txd;
          len_cnt_d    = LEN_W'(1);
        end else if (!src_req) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d         = ST_IFG;
          grant_timeout_d = 1'b1;
          ifg_cnt_d       = '0;
          rr_ptr_d        = rr_after(sel_q, rr_ptr_q);
        end else begin
          wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_SEND: begin
        if (src_tx_en && len_cnt_q != LEN_MAX) begin
          gmii_tx_en_d = 1'b1;
          gmii_txd_d   = src_txd;
          len_cnt_d    = len_cnt_q + LEN_W'(1);
        end else begin
          state_d   = ST_IFG;
          ifg_cnt_d = '0;
          rr_ptr_d  = rr_after(sel_q, rr_ptr_q);
          if (src_tx_en) begin
            frame_abort_d = 1'b1;
            hold_d[sel_q] = 1'b1;
          end
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q == IFG_LAST) state_d = ST_IDLE;
        else ifg_cnt_d = (ifg_cnt_q == IFG_MAX) ? ifg_cnt_q : ifg_cnt_q + IFG_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      sel_q           <= SRC_ARP;
      rr_ptr_q        <= SRC_AUD;
      hold_q          <= '0;
      gmii_tx_en_q    <= 1'b0;
      gmii_txd_q      <= '0;
      frame_abort_q   <= 1'b0;
      grant_timeout_q <= 1'b0;
      ifg_cnt_q       <= '0;
      wait_cnt_q      <= '0;
      len_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      rr_ptr_q        <= rr_ptr_d;
      hold_q          <= hold_d;
      gmii_tx_en_q    <= gmii_tx_en_d;
      gmii_txd_q      <= gmii_txd_d;
      frame_abort_q   <= frame_abort_d;
      grant_timeout_q <= grant_timeout_d;
      ifg_cnt_q       <= ifg_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      len_cnt_q       <= len_cnt_d;
    end
  end

  assign busy          = (state_q == ST_GRANT) || (state_q == ST_SEND);
  assign arp_gnt       = busy && (sel_q == SRC_ARP);
  assign aud_gnt       = busy && (sel_q == SRC_AUD);
  assign vid_gnt       = busy && (sel_q == SRC_VID);
  assign gmii_tx_en    = gmii_tx_en_q;
  assign gmii_txd      = gmii_txd_q;
  assign frame_abort   = frame_abort_q;
  assign grant_timeout = grant_timeout_q;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: a cycle table for basic muxing/arbitration plus
// scripted sequences for gap, timeout, length-limit, round-robin and reset corners.
module tb_eth_tx_arbiter;
  localparam int IFG  = 12;
  localparam int TMO  = 255;
  localparam int MAXF = 1530;
  localparam int ARP = 0, AUD = 1, VID = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] tx_en = '0;
  logic [7:0] txd [3];
  logic       arp_gnt, aud_gnt, vid_gnt, gmii_tx_en, frame_abort, grant_timeout;
  logic [7:0] gmii_txd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.IFG_CYCLES(IFG), .START_TIMEOUT(TMO), .MAX_FRAME_CYCLES(MAXF)) dut (
    .clk(clk), .rst(rst),
    .arp_req(req[0]), .arp_tx_en(tx_en[0]), .arp_txd(txd[0]),
    .aud_req(req[1]), .aud_tx_en(tx_en[1]), .aud_txd(txd[1]),
    .vid_req(req[2]), .vid_tx_en(tx_en[2]), .vid_txd(txd[2]),
    .arp_gnt(arp_gnt), .aud_gnt(aud_gnt), .vid_gnt(vid_gnt),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .frame_abort(frame_abort), .grant_timeout(grant_timeout)
  );

  typedef struct {
    int         rep;
    logic [2:0] req;
    logic [2:0] en;
    logic [7:0] d0, d1, d2;
    logic [2:0] egnt;
    logic       eten;
    logic [7:0] etxd;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gnt();
    return {vid_gnt, aud_gnt, arp_gnt};
  endfunction

  function automatic logic [7:0] pat(input int src, input int i);
    return 8'(src * 64 + i * 3 + 1);
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; tx_en = '0;
    txd[0] = '0; txd[1] = '0; txd[2] = '0;
    step(); step();
    rst = 1'b0;
    chk("reset gnt", gnt(), 0);
    chk("reset tx_en", gmii_tx_en, 0);
    chk("reset txd", gmii_txd, 0);
    chk("reset abort", frame_abort, 0);
    chk("reset timeout", grant_timeout, 0);
  endtask

  // Wait for a grant, check it, send nbytes while other sources drive junk, end the frame.
  task automatic serve(input int src, input int nbytes, input bit drop_req,
                       input int arp_at, input int exp_wait, input string tag);
    int waited = 0;
    while (gnt() == 3'b000 && waited < 3000) begin
      step();
      waited++;
    end
    chk({tag, " grant"}, gnt(), 1 << src);
    if (exp_wait >= 0) chk({tag, " gap"}, waited, exp_wait);
    for (int i = 0; i < nbytes; i++) begin
      tx_en = 3'b111;
      for (int k = 0; k < 3; k++) txd[k] = 8'hEE;
      txd[src] = pat(src, i);
      if (i == arp_at) req[0] = 1'b1;
      step();
      chk({tag, " data en"}, gmii_tx_en, 1);
      chk({tag, " data"}, gmii_txd, pat(src, i));
      chk({tag, " gnt held"}, gnt(), 1 << src);
    end
    tx_en = '0;
    for (int k = 0; k < 3; k++) txd[k] = 8'h77;
    if (drop_req) req[src] = 1'b0;
    step();
    chk({tag, " end en"}, gmii_tx_en, 0);
    chk({tag, " end txd"}, gmii_txd, 0);
    chk({tag, " end gnt"}, gnt(), 0);
  endtask

  initial begin
    int n, hi, ab_at, ab_n, late;
    txd[0] = '0; txd[1] = '0; txd[2] = '0;

    tbl[0]  = '{1,  3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00};
    tbl[1]  = '{1,  3'b001, 3'b000, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 8'h00};
    tbl[2]  = '{1,  3'b001, 3'b011, 8'hA5, 8'h3C, 8'h00, 3'b001, 1'b1, 8'hA5};
    tbl[3]  = '{1,  3'b000, 3'b001, 8'h5A, 8'h00, 8'h00, 3'b001, 1'b1, 8'h5A};
    tbl[4]  = '{1,  3'b100, 3'b001, 8'hC3, 8'h00, 8'h00, 3'b001, 1'b1, 8'hC3};
    tbl[5]  = '{1,  3'b100, 3'b000, 8'hFF, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00};
    tbl[6]  = '{IFG, 3'b100, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00};
    tbl[7]  = '{1,  3'b100, 3'b000, 8'h00, 8'h00, 8'h00, 3'b100, 1'b0, 8'h00};
    tbl[8]  = '{1,  3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00};
    tbl[9]  = '{1,  3'b110, 3'b000, 8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'h00};
    tbl[10] = '{1,  3'b110, 3'b110, 8'h00, 8'h12, 8'h99, 3'b010, 1'b1, 8'h12};
    tbl[11] = '{1,  3'b110, 3'b100, 8'h00, 8'h34, 8'h99, 3'b000, 1'b0, 8'h00};

    do_reset();
    for (int r = 0; r < 12; r++) begin
      req = tbl[r].req; tx_en = tbl[r].en;
      txd[0] = tbl[r].d0; txd[1] = tbl[r].d1; txd[2] = tbl[r].d2;
      for (int k = 0; k < tbl[r].rep; k++) begin
        step();
        chk($sformatf("vec%0d gnt", r), gnt(), tbl[r].egnt);
        chk($sformatf("vec%0d en", r), gmii_tx_en, tbl[r].eten);
        chk($sformatf("vec%0d txd", r), gmii_txd, tbl[r].etxd);
      end
    end

    // All three pending: ARP by priority, then audio, then video, each after a full gap.
    do_reset();
    req = 3'b111;
    serve(ARP, 4, 1'b1, -1, 1, "t1 arp");
    serve(AUD, 4, 1'b1, -1, IFG + 1, "t1 aud");
    serve(VID, 4, 1'b1, -1, IFG + 1, "t1 vid");

    // 64-byte audio frame.
    do_reset();
    req[AUD] = 1'b1;
    serve(AUD, 64, 1'b1, -1, 1, "t2 aud64");

    // Video never starts: grant revoked after START_TIMEOUT, audio served next.
    do_reset();
    req[VID] = 1'b1;
    step();
    chk("t3 vid gnt", gnt(), 3'b100);
    req[AUD] = 1'b1;
    n = 0;
    while (!grant_timeout && n < 400) begin
      step();
      n++;
    end
    chk("t3 timeout cycle", n, TMO);
    chk("t3 gnt dropped", gnt(), 0);
    step();
    chk("t3 timeout pulse width", grant_timeout, 0);
    serve(AUD, 3, 1'b1, -1, IFG, "t3 aud");

    // Runaway audio frame cut at MAX_FRAME_CYCLES, not re-granted while tx_en stays high.
    do_reset();
    req[AUD] = 1'b1;
    step();
    chk("t4 aud gnt", gnt(), 3'b010);
    hi = 0; ab_at = -1; ab_n = 0; late = 0;
    for (int i = 0; i < 2000; i++) begin
      tx_en[AUD] = 1'b1;
      txd[AUD] = pat(AUD, i);
      step();
      if (gmii_tx_en) begin
        hi++;
        if (i >= MAXF) late++;
      end
      if (frame_abort) begin
        ab_n++;
        ab_at = i;
      end
      if (i > MAXF && gnt() != 3'b000) late++;
    end
    chk("t4 high cycles", hi, MAXF);
    chk("t4 abort index", ab_at, MAXF);
    chk("t4 abort pulses", ab_n, 1);
    chk("t4 no resume", late, 0);
    tx_en = '0;
    serve(AUD, 3, 1'b1, -1, -1, "t4 resume");

    // Continuous aud/vid alternate; ARP raised mid-frame goes next.
    do_reset();
    req = 3'b110;
    serve(AUD, 5, 1'b0, -1, 1, "t5 aud1");
    serve(VID, 5, 1'b0, 2, IFG + 1, "t5 vid1");
    serve(ARP, 3, 1'b1, -1, IFG + 1, "t5 arp");
    serve(AUD, 3, 1'b0, -1, IFG + 1, "t5 aud2");
    serve(VID, 3, 1'b1, -1, IFG + 1, "t5 vid2");

    // Reset during a video frame truncates output and restores rr_ptr to audio.
    do_reset();
    req[AUD] = 1'b1;
    serve(AUD, 3, 1'b1, -1, 1, "t6 aud");
    req[VID] = 1'b1;
    n = 0;
    while (gnt() == 3'b000 && n < 100) begin
      step();
      n++;
    end
    chk("t6 vid gnt", gnt(), 3'b100);
    for (int i = 0; i < 10; i++) begin
      tx_en[VID] = 1'b1;
      txd[VID] = pat(VID, i);
      step();
    end
    chk("t6 sending", gmii_tx_en, 1);
    rst = 1'b1;
    step();
    chk("t6 rst en", gmii_tx_en, 0);
    chk("t6 rst txd", gmii_txd, 0);
    chk("t6 rst gnt", gnt(), 0);
    rst = 1'b0;
    tx_en = '0;
    req = 3'b110;
    serve(AUD, 2, 1'b1, -1, 1, "t6 rr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
